// File: rtl/event_encoder.sv
// event_encoder: sticky 8-to-3 priority encoder with a valid/ready output.
// Event pulses on `in` latch into pending flags. The index of the winning flag
// is presented on `out`, and that flag clears when the consumer accepts it.
// Default priority: the highest pending index wins.
// Optional build macro EVENT_ENCODER_RR_EN: round-robin priority instead. The
// search starts at last_grant+1 and wraps from WIDTH-1 to 0.
module event_encoder #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [IDX_W-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] pending,
  output logic             overflow
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] out_q, out_d;
  logic [WIDTH-1:0] pend_q, pend_d, clr_mask;
  logic             ovf_q, ovf_d;
  logic             accept, any_next;
  logic [IDX_W-1:0] enc;

  assign accept   = (state_q == PRESENT) && out_ready;
  assign any_next = |pend_d;

  // Clear the flag of the code being accepted; a same-cycle pulse still wins below
  always_comb begin
    clr_mask = '0;
    if (accept) clr_mask[out_q] = 1'b1;
  end

  // Next pending flags and sticky overflow (pulse onto a flag that stays pending)
  always_comb begin
    pend_d = (pend_q & ~clr_mask) | in;
    ovf_d  = ovf_q | (|(in & pend_q & ~clr_mask));
  end

`ifdef EVENT_ENCODER_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d, start, idx;
  logic             found;

  // On acceptance the search starts right after the grant just taken, so the
  // code presented next already sees the advanced pointer
  always_comb begin
    start = accept ? out_q + IDX_W'(1) : ptr_q;
    ptr_d = accept ? out_q + IDX_W'(1) : ptr_q;
    enc   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      idx = start + IDX_W'(i);
      if (!found && pend_d[idx]) begin
        enc   = idx;
        found = 1'b1;
      end
    end
  end

  // Round-robin pointer moves only on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  // Fixed priority: scanning upward, the last set bit found is the highest index
  always_comb begin
    enc = '0;
    for (int i = 0; i < WIDTH; i++)
      if (pend_d[i]) enc = IDX_W'(i);
  end
`endif

  // Pending flags and overflow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  // FSM state and presented code registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  // Next state: leave PRESENT only when the last pending code is accepted
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_next) state_d = PRESENT;
      PRESENT: if (out_ready && !any_next) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output code: load a new code on entry or acceptance, otherwise hold it
  always_comb begin
    out_d = out_q;
    case (state_q)
      IDLE:    if (any_next) out_d = enc;
      PRESENT: if (out_ready && any_next) out_d = enc;
      default: out_d = out_q;
    endcase
  end

  assign out       = out_q;
  assign out_valid = (state_q == PRESENT);
  assign pending   = pend_q;
  assign overflow  = ovf_q;

endmodule
